// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and default phase lengths for the junction controller
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GREEN = 3'd2,
        ST_AMBER = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int DEFAULT_NUM_WAYS     = 4;
    localparam int DEFAULT_GREEN_PERIOD = 10000;
    localparam int DEFAULT_AMBER_PERIOD = 3000;
    localparam int DEFAULT_CLEAR_PERIOD = 1000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - picks the first pending way after the last served one, wrapping around
module rr_arbiter #(
    parameter int NUM_WAYS = 4,
    parameter int IW       = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] pending,
    input  logic [IW-1:0]       last_served,
    output logic [IW-1:0]       next_way,
    output logic                next_valid
);

    int idx;

    // Scan ways last_served+1 .. last_served+NUM_WAYS; the served way itself is checked last.
    always_comb begin
        next_way   = '0;
        next_valid = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_WAYS; k++) begin
            idx = int'(last_served) + k;
            if (idx >= NUM_WAYS) begin
                idx = idx - NUM_WAYS;
            end
            if (!next_valid && pending[idx]) begin
                next_valid = 1'b1;
                next_way   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/traffic_junction.sv
// rtl/traffic_junction.sv - round-robin traffic light controller with blocked-exit hold and fixed phases
module traffic_junction
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS     = DEFAULT_NUM_WAYS,
    parameter int GREEN_PERIOD = DEFAULT_GREEN_PERIOD,
    parameter int AMBER_PERIOD = DEFAULT_AMBER_PERIOD,
    parameter int CLEAR_PERIOD = DEFAULT_CLEAR_PERIOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_WAYS-1:0] request,
    input  logic [NUM_WAYS-1:0] blocked,
    output logic [NUM_WAYS-1:0] red,
    output logic [NUM_WAYS-1:0] amber,
    output logic [NUM_WAYS-1:0] green,
    output logic [NUM_WAYS-1:0] active,
    output logic                busy
);

    localparam int IW    = $clog2(NUM_WAYS);
    localparam int MAX_P = (GREEN_PERIOD > AMBER_PERIOD)
                         ? ((GREEN_PERIOD > CLEAR_PERIOD) ? GREEN_PERIOD : CLEAR_PERIOD)
                         : ((AMBER_PERIOD > CLEAR_PERIOD) ? AMBER_PERIOD : CLEAR_PERIOD);
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    state_t                state, state_nxt;
    logic [CW-1:0]         counter, counter_nxt;
    logic [IW-1:0]         sel, sel_nxt;
    logic [IW-1:0]         last_served, last_nxt;
    logic [NUM_WAYS-1:0]   pending;
    logic [NUM_WAYS-1:0]   grant_clear;
    logic [IW-1:0]         next_way;
    logic                  next_valid;

    rr_arbiter #(
        .NUM_WAYS (NUM_WAYS),
        .IW       (IW)
    ) u_arb (
        .pending     (pending),
        .last_served (last_served),
        .next_way    (next_way),
        .next_valid  (next_valid)
    );

    // State, phase counter, selection and request latches; a new request beats the grant clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            counter     <= '0;
            sel         <= '0;
            last_served <= IW'(NUM_WAYS - 1);
            pending     <= '0;
        end else begin
            state       <= state_nxt;
            counter     <= counter_nxt;
            sel         <= sel_nxt;
            last_served <= last_nxt;
            pending     <= (pending & ~grant_clear) | request;
        end
    end

    // Next-state logic: select, wait for exit, then fixed green/amber/clear phases counted down to 0.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        sel_nxt     = sel;
        last_nxt    = last_served;
        grant_clear = '0;
        case (state)
            ST_IDLE: begin
                if (next_valid) begin
                    sel_nxt   = next_way;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!blocked[sel]) begin
                    state_nxt        = ST_GREEN;
                    counter_nxt      = CW'(GREEN_PERIOD - 1);
                    grant_clear[sel] = 1'b1;
                end
            end
            ST_GREEN: begin
                if (counter == '0) begin
                    state_nxt   = ST_AMBER;
                    counter_nxt = CW'(AMBER_PERIOD - 1);
                    last_nxt    = sel;
                end else begin
                    counter_nxt = counter - CW'(1);
                end
            end
            ST_AMBER: begin
                if (counter == '0) begin
                    state_nxt   = ST_CLEAR;
                    counter_nxt = CW'(CLEAR_PERIOD - 1);
                end else begin
                    counter_nxt = counter - CW'(1);
                end
            end
            ST_CLEAR: begin
                if (counter == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    counter_nxt = counter - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lights and activity decoded from the registered state so reset turns everything red at once.
    always_comb begin
        red    = '1;
        amber  = '0;
        green  = '0;
        active = pending;
        busy   = (state != ST_IDLE);
        for (int i = 0; i < NUM_WAYS; i++) begin
            green[i] = (state == ST_GREEN) && (sel == IW'(i));
            amber[i] = (state == ST_AMBER) && (sel == IW'(i));
            red[i]   = !green[i] && !amber[i];
            if ((state != ST_IDLE) && (sel == IW'(i))) begin
                active[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_junction.sv
// tb/tb_traffic_junction.sv - directed and randomized self-checking bench for traffic_junction
module tb_traffic_junction;

    localparam int N = 4;
    localparam int G = 5;
    localparam int A = 2;
    localparam int C = 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] blocked = '0;
    logic [N-1:0] red, amber, green, active;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference: a grant is a green start time; phase follows from elapsed cycles.
    bit       m_busy  = 1'b0;
    bit       m_wait  = 1'b0;
    int       m_sel   = 0;
    int       m_last  = N - 1;
    int       m_gstart = 0;
    bit [N-1:0] m_pend = '0;

    int           served[$];
    logic [N-1:0] prev_green = '0;

    traffic_junction #(
        .NUM_WAYS     (N),
        .GREEN_PERIOD (G),
        .AMBER_PERIOD (A),
        .CLEAR_PERIOD (C)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .blocked (blocked),
        .red     (red),
        .amber   (amber),
        .green   (green),
        .active  (active),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit [N-1:0] clr;
        int e;
        clr = '0;
        if (reset) begin
            m_busy = 1'b0;
            m_wait = 1'b0;
            m_sel  = 0;
            m_last = N - 1;
            m_pend = '0;
        end else begin
            if (!m_busy) begin
                if (m_pend != 0) begin
                    m_sel  = rr_pick(m_pend, m_last);
                    m_busy = 1'b1;
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (!blocked[m_sel]) begin
                    m_wait      = 1'b0;
                    m_gstart    = cyc + 1;
                    clr[m_sel]  = 1'b1;
                end
            end else begin
                e = cyc - m_gstart;
                if (e == G - 1) m_last = m_sel;
                if (e == G + A + C - 1) m_busy = 1'b0;
            end
            m_pend = (m_pend & ~clr) | request;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        int e;
        bit [N-1:0] eg, ea, er, eact, sel_oh;
        int nonred;
        bit ok;
        e      = cyc - m_gstart;
        sel_oh = m_busy ? (N'(1) << m_sel) : '0;
        eg     = (m_busy && !m_wait && e < G) ? sel_oh : '0;
        ea     = (m_busy && !m_wait && e >= G && e < G + A) ? sel_oh : '0;
        er     = ~(eg | ea);
        eact   = m_pend | sel_oh;
        chk("green", 32'(green), 32'(eg));
        chk("amber", 32'(amber), 32'(ea));
        chk("red", 32'(red), 32'(er));
        chk("active", 32'(active), 32'(eact));
        chk("busy", 32'(busy), 32'(m_busy));
        ok = 1'b1;
        nonred = 0;
        for (int i = 0; i < N; i++) begin
            if ((int'(red[i]) + int'(amber[i]) + int'(green[i])) != 1) ok = 1'b0;
            if (!red[i]) nonred++;
        end
        if (nonred > 1) ok = 1'b0;
        chk("invariant", 32'(ok), 32'd1);
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] blk, input logic rst);
        request = req;
        blocked = blk;
        reset   = rst;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        if (green != '0 && prev_green == '0) begin
            for (int i = 0; i < N; i++) if (green[i]) served.push_back(i);
        end
        prev_green = green;
    endtask

    initial begin
        int exp_rr[5];
        int exp_rq[3];
        bit found;

        // reset state
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        chk("rst_red", 32'(red), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(active), 32'd0);

        // single request on way 2: green n+3..n+7, amber n+8..n+9, clear n+10, idle n+11
        cycle(4'b0100, '0, 1'b0);
        for (int k = 2; k <= 12; k++) begin
            cycle('0, '0, 1'b0);
            if (k == 2)  chk("single_pre", 32'(green), 32'd0);
            if (k == 3)  chk("single_rise", 32'(green), 32'b0100);
            if (k == 7)  chk("single_last", 32'(green), 32'b0100);
            if (k == 8)  chk("single_amber", 32'(amber), 32'b0100);
            if (k == 10) chk("single_clear", 32'(red), 32'hF);
            if (k == 11) chk("single_idle", 32'(busy), 32'd0);
        end

        // round robin with all ways requesting
        cycle('0, '0, 1'b1);
        served.delete();
        for (int k = 0; k < 55; k++) cycle(4'b1111, '0, 1'b0);
        exp_rr = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(served.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < served.size(); i++) chk("rr_order", 32'(served[i]), 32'(exp_rr[i]));

        // blocked exit holds in WAIT
        cycle('0, '0, 1'b1);
        cycle(4'b0010, 4'b0010, 1'b0);
        for (int k = 0; k < 9; k++) cycle('0, 4'b0010, 1'b0);
        chk("blk_red", 32'(red[1]), 32'd1);
        chk("blk_active", 32'(active[1]), 32'd1);
        chk("blk_busy", 32'(busy), 32'd1);
        cycle('0, '0, 1'b0);
        chk("blk_release", 32'(green[1]), 32'd1);
        for (int k = 0; k < 12; k++) cycle('0, '0, 1'b0);

        // held re-request on way 0 yields to pending way 3
        cycle('0, '0, 1'b1);
        served.delete();
        cycle(4'b1001, '0, 1'b0);
        for (int k = 0; k < 40; k++) cycle(4'b0001, '0, 1'b0);
        exp_rq = '{0, 3, 0};
        chk("rq_count", 32'(served.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < served.size(); i++) chk("rq_order", 32'(served[i]), 32'(exp_rq[i]));

        // reset during the second green cycle of way 1
        cycle('0, '0, 1'b1);
        cycle(4'b0010, '0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (green == 4'b0010) found = 1'b1;
            else cycle('0, '0, 1'b0);
        end
        chk("mid_green_seen", 32'(found), 32'd1);
        cycle('0, '0, 1'b0);
        cycle('0, '0, 1'b1);
        chk("mid_red", 32'(red), 32'hF);
        chk("mid_amber", 32'(amber), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_pending", 32'(active), 32'd0);

        // randomized traffic against the reference
        for (int k = 0; k < 800; k++) begin
            logic [N-1:0] rq, bk;
            logic rs;
            rq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bk = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rs = ($urandom_range(0, 249) == 0);
            cycle(rq, bk, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_junction.md
TRAFFIC_JUNCTION -- requirements
Module: traffic_junction

Interface
REQ-001 Parameter NUM_WAYS, default 4, number of approaches; SHALL be 2..16.
REQ-002 Parameter GREEN_PERIOD, default 10000, green cycles per grant; SHALL be >= 1.
REQ-003 Parameter AMBER_PERIOD, default 3000, amber cycles per grant; SHALL be >= 1.
REQ-004 Parameter CLEAR_PERIOD, default 1000, all-red clearance cycles; SHALL be >= 1.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 request  input  NUM_WAYS  per-way service request, level, sampled each cycle.
REQ-008 blocked  input  NUM_WAYS  per-way exit blocked; the selected way cannot turn green while its bit is high.
REQ-009 red  output  NUM_WAYS  way shows red.
REQ-010 amber  output  NUM_WAYS  way shows amber.
REQ-011 green  output  NUM_WAYS  way shows green.
REQ-012 active  output  NUM_WAYS  way has a pending request or is currently selected.
REQ-013 busy  output  1  controller not in IDLE.

Function
REQ-014 pending[i] SHALL be set at the clock edge where request[i]=1 and cleared at the edge entering GREEN for way i; set wins over clear in the same cycle.
REQ-015 States SHALL be IDLE, WAIT, GREEN, AMBER, CLEAR.
REQ-016 IDLE: if any pending bit is set, select the first pending way after last_served in round-robin order (wrapping NUM_WAYS-1 -> 0) and go to WAIT; otherwise stay. blocked SHALL NOT affect selection.
REQ-017 WAIT: hold while blocked[sel]=1; when blocked[sel]=0, go to GREEN and load counter with GREEN_PERIOD-1.
REQ-018 GREEN: decrement counter each cycle; at counter=0 go to AMBER and load AMBER_PERIOD-1; last_served <= sel. Green SHALL last exactly GREEN_PERIOD cycles regardless of blocked or request.
REQ-019 AMBER: count down the same way; at 0 go to CLEAR and load CLEAR_PERIOD-1.
REQ-020 CLEAR: count down; at 0 go to IDLE. All ways SHALL show red throughout CLEAR.
REQ-021 green[i]=(state==GREEN && sel==i); amber[i]=(state==AMBER && sel==i); red[i]=!green[i] && !amber[i]. Exactly one of red/amber/green SHALL be high per way, and at most one way SHALL be non-red.
REQ-022 active[i]=pending[i] || (state!=IDLE && sel==i); busy=(state!=IDLE).
REQ-023 Counter width SHALL be $clog2 of the largest period and SHALL never wrap below 0.
REQ-024 From the cycle request[i] is first high with the controller idle and way i unblocked, green[i] SHALL rise 3 cycles later.
REQ-025 A request on the served way during GREEN, AMBER or CLEAR SHALL re-set pending and be served again only after all other pending ways in round-robin order.

Reset
REQ-026 On reset: state=IDLE, pending=0, counter=0, sel=0, last_served=NUM_WAYS-1 (way 0 has first priority); red=all ones, amber=0, green=0, active=0, busy=0.
REQ-027 Reset asserted in any state SHALL take effect at the next edge: lights go all-red immediately and the grant is abandoned without an amber or clearance phase.

Structure
REQ-028 Package traffic_pkg SHALL hold the state enum and the default period constants.
REQ-029 Round-robin selection SHALL be implemented as sub-module rr_arbiter (inputs: pending, last_served; output: next way index and valid).

Verification (NUM_WAYS=4, GREEN=5, AMBER=2, CLEAR=1)
REQ-030 Single request: request[2] high in cycle n, nothing blocked -> green[2] high in cycles n+3..n+7, amber[2] in n+8..n+9, all red in n+10, busy low from n+11.
REQ-031 Round robin: request=4'b1111 held from reset -> ways are served 0,1,2,3,0 in that order, with no overlap of non-red lights.
REQ-032 Blocked wait: request[1] with blocked[1]=1 for 10 cycles -> controller holds in WAIT with red[1]=1 and active[1]=1; green[1] rises 1 cycle after blocked[1] drops.
REQ-033 Re-request: request[0] held continuously while way 3 is also pending -> way 3 is served before way 0 is served a second time.
REQ-034 Reset mid-green: reset pulsed during cycle 2 of green[1] -> next cycle red=4'b1111, amber=0, pending=0, busy=0.
REQ-035 Invariants checked formally every cycle: one-hot light per way, at most one way non-red, counter never exceeds its loaded period.
